// File: rtl/hamming_pkg.sv
// Shared definitions for the sequential Hamming-weight unit: FSM state
// encoding and a constant-foldable ceil(log2) helper used for derived widths.
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hw_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int hw_clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of an N-bit slice.
// Built as a balanced binary tree (heap-indexed) of ripple-carry adders made
// from half/full adder cells. Leaves beyond N are tied to zero so the tree can
// always be a power of two wide. Each node is OW bits wide; no node sum can
// exceed N, so the dropped carry out of the top bit is always zero.
module popcount_chunk
  import hamming_pkg::*;
#(
  parameter int N = 8,
  localparam int OW  = hw_clog2(N + 1),
  localparam int LVL = hw_clog2(N),
  localparam int P   = 1 << LVL
) (
  input  logic [N-1:0]  in_bits,
  output logic [OW-1:0] count
);

  // Node 0 is the root; node i has children 2i+1 and 2i+2; leaves at P-1..2P-2.
  logic [OW-1:0] node_s [2*P-1];

  genvar j;
  generate
    for (j = 0; j < P; j++) begin : g_leaf
      if (j < N) begin : g_real
        assign node_s[P-1+j] = OW'(in_bits[j]);
      end else begin : g_pad
        assign node_s[P-1+j] = '0;
      end
    end
  endgenerate

  genvar i, b;
  generate
    for (i = 0; i < P - 1; i++) begin : g_node
      logic [OW-1:0] lhs_s;
      logic [OW-1:0] rhs_s;
      logic [OW-1:0] sum_s;
      logic [OW-1:0] carry_s;

      assign lhs_s      = node_s[2*i+1];
      assign rhs_s      = node_s[2*i+2];
      assign carry_s[0] = 1'b0;

      for (b = 0; b < OW; b++) begin : g_bit
        assign sum_s[b] = lhs_s[b] ^ rhs_s[b] ^ carry_s[b];
        if (b < OW - 1) begin : g_cout
          assign carry_s[b+1] = (lhs_s[b] & rhs_s[b]) |
                                (lhs_s[b] & carry_s[b]) |
                                (rhs_s[b] & carry_s[b]);
        end
      end

      assign node_s[i] = sum_s;
    end
  endgenerate

  assign count = node_s[0];

endmodule

// File: rtl/hamming_weight_seq.sv
// Multi-cycle Hamming-weight unit: counts CHUNK bits per cycle with a shared
// combinational chunk counter and accumulates into a CW-bit result.
// Optional feature macro: HAMMING_DIST_EN -- adds in_data_b and counts the
// bits of in_data ^ in_data_b (Hamming distance) with identical timing.
module hamming_weight_seq
  import hamming_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = hw_clog2(WIDTH + 1),
  localparam int IW     = (hw_clog2(NCHUNK) > 1) ? hw_clog2(NCHUNK) : 1,
  localparam int PW     = hw_clog2(CHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef HAMMING_DIST_EN
  input  logic [WIDTH-1:0] in_data_b,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  hw_state_e        state_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] operand_s;
  logic [CW-1:0]    acc_r;
  logic [CW-1:0]    acc_next_s;
  logic [IW-1:0]    idx_r;
  logic [PW-1:0]    chunk_cnt_s;
  logic             last_s;
  logic             accept_s;

`ifdef HAMMING_DIST_EN
  assign operand_s = in_data ^ in_data_b;
`else
  assign operand_s = in_data;
`endif

  popcount_chunk #(
    .N(CHUNK)
  ) u_popcount_chunk (
    .in_bits(shift_r[CHUNK-1:0]),
    .count  (chunk_cnt_s)
  );

  assign acc_next_s = acc_r + CW'(chunk_cnt_s);
  assign last_s     = (idx_r == IW'(NCHUNK - 1));

  // Ready in IDLE, or in DONE when the result is being taken this cycle so a
  // new operand can be loaded without an idle bubble.
  assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s = in_valid && in_ready;

  // Control FSM plus datapath registers; all status outputs except in_ready are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      acc_r     <= '0;
      idx_r     <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shift_r <= operand_s;
            acc_r   <= '0;
            idx_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          shift_r <= shift_r >> CHUNK;
          idx_r   <= idx_r + IW'(1);
          if (last_s) begin
            out_count <= acc_next_s;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              shift_r <= operand_s;
              acc_r   <= '0;
              idx_r   <= '0;
              busy    <= 1'b1;
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_weight_seq.sv
// Directed bench for hamming_weight_seq: a 32/8 instance for the main
// behaviour and an 8/8 instance for the single-chunk case.
module tb_hamming_weight_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, in_data_b;
  logic [5:0]  out_count;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_data8, in_data_b8;
  logic [3:0]  out_count8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_weight_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef HAMMING_DIST_EN
    .in_data_b(in_data_b),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .busy     (busy)
  );

  hamming_weight_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_data  (in_data8),
`ifdef HAMMING_DIST_EN
    .in_data_b(in_data_b8),
`endif
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .out_count(out_count8),
    .busy     (busy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    in_data   = a;
    in_data_b = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Called just after acceptance; expects out_valid after exactly 4 edges.
  task automatic wait_result(input string tag, input logic [31:0] exp);
    int lat    = 0;
    int busy_n = 0;
    int ir_bad = 0;
    while (!out_valid && lat < 50) begin
      if (busy) busy_n++;
      if (in_ready) ir_bad++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"},     32'(lat),       32'd4);
    chk({tag, "_busy"},    32'(busy_n),    32'd4);
    chk({tag, "_rdy_run"}, 32'(ir_bad),    32'd0);
    chk({tag, "_cnt"},     32'(out_count), exp);
    chk({tag, "_busy_dn"}, 32'(busy),      32'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int bad;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data    = 32'd0;
    in_data_b  = 32'd0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    in_data8   = 8'd0;
    in_data_b8 = 8'd0;

    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst8_in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero and all-one operands.
    send(32'h0000_0000, 32'h0);
    wait_result("zero", 32'd0);
    consume("zero");
    send(32'hFFFF_FFFF, 32'h0);
    wait_result("ones", 32'd32);
    consume("ones");

    // Mixed pattern, then back-pressure for 5 cycles.
    send(32'hA5A5_0F01, 32'h0);
    wait_result("mix", 32'd13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ov",  32'(out_valid), 32'd1);
      chk("hold_cnt", 32'(out_count), 32'd13);
      chk("hold_rdy", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("done_rdy_follow", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_ov",  32'(out_valid), 32'd0);
    chk("rel_rdy", 32'(in_ready),  32'd1);

    // Result consumed and new operand loaded in the same cycle.
    send(32'h0000_00FF, 32'h0);
    wait_result("pre_b2b", 32'd8);
    in_data   = 32'h8000_0001;
    in_data_b = 32'h0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_ov_drop", 32'(out_valid), 32'd0);
    chk("b2b_busy",    32'(busy),      32'd1);
    wait_result("b2b", 32'd2);
    consume("b2b");

    // Asynchronous reset during the second RUN cycle.
    send(32'hFFFF_FFFF, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_count", 32'(out_count), 32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || busy) bad++;
    end
    chk("arst_quiet",    32'(bad),      32'd0);
    chk("arst_rdy_idle", 32'(in_ready), 32'd1);

`ifdef HAMMING_DIST_EN
    send(32'hFFFF_0000, 32'h0000_FFFF);
    wait_result("dist_all", 32'd32);
    consume("dist_all");
    send(32'h1234_5678, 32'h1234_5678);
    wait_result("dist_eq", 32'd0);
    consume("dist_eq");
`endif

    // Single-chunk instance: 0xB6 has 5 bits set, result one edge after acceptance.
    in_data8  = 8'hB6;
    in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("w8_lat", 32'(lat),        32'd1);
    chk("w8_cnt", 32'(out_count8), 32'd5);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("w8_ov_drop", 32'(out_valid8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
